// File: rtl/uarc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uarc_bus_pkg
//  Purpose  : Shared types for the UARC point-to-point bus link: control
//             state encoding and the buffered word layout {is_stream, data}.
//  Revision : 1.0 - initial release
// ============================================================================
package uarc_bus_pkg;

    // Default word geometry of a UARC bus.
    localparam int UARC_WORD_MAG   = 5;
    localparam int UARC_WORD_WIDTH = 1 << UARC_WORD_MAG;

    // Control handshake sequencer states.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        INCEPT_WAIT = 3'd1,
        INCEPT_DONE = 3'd2,
        KILL_WAIT   = 3'd3,
        KILL_DONE   = 3'd4
    } ctrl_state_t;

    // One buffered word: stream words and send words share the queue so
    // their relative order is preserved.
    typedef struct packed {
        logic                       is_stream;
        logic [UARC_WORD_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/uarc_bus_link_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uarc_bus_link_fifo
//  Purpose  : Count-based synchronous FIFO with single-edge flush. No
//             fall-through: a word written into an empty queue becomes the
//             head on the following cycle. A pop while full frees the slot
//             only after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module uarc_bus_link_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_MAG = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int                 DEPTH       = 1 << DEPTH_MAG;
    localparam logic [DEPTH_MAG:0] DEPTH_COUNT = (DEPTH_MAG+1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_MAG-1:0] wr_ptr;
    logic [DEPTH_MAG-1:0] rd_ptr;
    logic [DEPTH_MAG:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == DEPTH_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_MAG'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_MAG'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_MAG+1)'(1);
                2'b01:   count <= count - (DEPTH_MAG+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Word storage; cleared on reset so the head reads zero until written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uarc_bus_link.sv
`default_nettype none
// ============================================================================
//  Module   : uarc_bus_link
//  Purpose  : One UARC bus channel between a sender core and a receiver
//             core. Send/stream words are queued; kill and incept handshakes
//             are sequenced so control never overtakes earlier data.
//             The queued word layout is shared through uarc_bus_pkg, so
//             WORD_MAG must match UARC_WORD_MAG.
//  Revision : 1.0 - initial release
// ============================================================================
module uarc_bus_link
    import uarc_bus_pkg::*;
#(
    parameter  int WORD_MAG   = UARC_WORD_MAG,
    parameter  int FIFO_MAG   = 2,
    localparam int WORD_WIDTH = 1 << WORD_MAG
)(
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  s_enable,
    input  logic                  s_kill,
    input  logic                  s_incept,
    input  logic                  s_send,
    input  logic                  s_stream,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic [WORD_WIDTH-1:0] s_self_permission,
    input  logic [WORD_WIDTH-1:0] s_self_address,
    input  logic [WORD_WIDTH-1:0] s_incept_permission,
    input  logic [WORD_WIDTH-1:0] s_incept_address,
    output logic                  s_kill_ack,
    output logic                  s_incept_ack,
    output logic                  s_send_ack,
    output logic                  s_stream_ack,

    output logic                  r_enable,
    output logic                  r_kill,
    output logic                  r_incept,
    output logic                  r_send,
    output logic                  r_stream,
    output logic [WORD_WIDTH-1:0] r_data,
    output logic [WORD_WIDTH-1:0] r_self_permission,
    output logic [WORD_WIDTH-1:0] r_self_address,
    output logic [WORD_WIDTH-1:0] r_incept_permission,
    output logic [WORD_WIDTH-1:0] r_incept_address,
    input  logic                  r_kill_ack,
    input  logic                  r_incept_ack,
    input  logic                  r_send_ack,
    input  logic                  r_stream_ack
);

    ctrl_state_t           state;
    fifo_entry_t           push_entry;
    fifo_entry_t           head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  idle;
    logic                  in_kill;
    logic                  kill_go;
    logic                  incept_go;
    logic                  accept_ok;
    logic                  out_kill;
    logic                  out_incept;
    logic                  kill_done;
    logic                  incept_done;
    logic [WORD_WIDTH-1:0] cap_self_permission;
    logic [WORD_WIDTH-1:0] cap_self_address;
    logic [WORD_WIDTH-1:0] cap_incept_permission;
    logic [WORD_WIDTH-1:0] cap_incept_address;

    assign idle    = (state == IDLE);
    assign in_kill = (state == KILL_WAIT) || (state == KILL_DONE);

    // A kill outranks every other request, including a word offered in the
    // same cycle, so nothing is acked only to be flushed at the same edge.
    assign kill_go   = s_enable & s_kill & ~in_kill;
    // Reset gating keeps the combinational acks low while reset is held.
    assign accept_ok = reset & idle & s_enable & ~s_kill & ~fifo_full;

    assign s_send_ack   = accept_ok & s_send & ~s_stream;
    assign s_stream_ack = accept_ok & s_stream & ~s_send;
    assign push         = s_send_ack | s_stream_ack;

    // Incept starts only once earlier data has drained; a word accepted in
    // the same cycle is treated as preceding it.
    assign incept_go = idle & s_enable & s_incept & ~s_kill & fifo_empty & ~push;

    assign push_entry = {s_stream, s_data};

    assign r_send   = ~fifo_empty & ~head_entry.is_stream;
    assign r_stream = ~fifo_empty & head_entry.is_stream;
    assign r_data   = head_entry.data;
    assign pop      = (r_send & r_send_ack) | (r_stream & r_stream_ack);

    assign r_enable     = ~fifo_empty | ~idle;
    assign r_kill       = out_kill;
    assign r_incept     = out_incept;
    assign s_kill_ack   = kill_done;
    // A kill landing on the acknowledge cycle still cancels the incept.
    assign s_incept_ack = incept_done & ~kill_go;

    assign r_self_permission   = cap_self_permission;
    assign r_self_address      = cap_self_address;
    assign r_incept_permission = cap_incept_permission;
    assign r_incept_address    = cap_incept_address;

    uarc_bus_link_fifo #(
        .WIDTH     ($bits(fifo_entry_t)),
        .DEPTH_MAG (FIFO_MAG)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (kill_go),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_entry)
    );

    // Kill/incept handshake sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            out_kill              <= 1'b0;
            out_incept            <= 1'b0;
            kill_done             <= 1'b0;
            incept_done           <= 1'b0;
            cap_self_permission   <= '0;
            cap_self_address      <= '0;
            cap_incept_permission <= '0;
            cap_incept_address    <= '0;
        end else if (kill_go) begin
            state                 <= KILL_WAIT;
            out_kill              <= 1'b1;
            out_incept            <= 1'b0;
            kill_done             <= 1'b0;
            incept_done           <= 1'b0;
            cap_self_permission   <= '0;
            cap_self_address      <= '0;
            cap_incept_permission <= '0;
            cap_incept_address    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (incept_go) begin
                        state                 <= INCEPT_WAIT;
                        out_incept            <= 1'b1;
                        cap_self_permission   <= s_self_permission;
                        cap_self_address      <= s_self_address;
                        cap_incept_permission <= s_incept_permission;
                        cap_incept_address    <= s_incept_address;
                    end
                end
                INCEPT_WAIT: begin
                    if (r_incept_ack) begin
                        state       <= INCEPT_DONE;
                        out_incept  <= 1'b0;
                        incept_done <= 1'b1;
                    end
                end
                INCEPT_DONE: begin
                    state       <= IDLE;
                    incept_done <= 1'b0;
                end
                KILL_WAIT: begin
                    if (r_kill_ack) begin
                        state     <= KILL_DONE;
                        out_kill  <= 1'b0;
                        kill_done <= 1'b1;
                    end
                end
                KILL_DONE: begin
                    state     <= IDLE;
                    kill_done <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    out_kill    <= 1'b0;
                    out_incept  <= 1'b0;
                    kill_done   <= 1'b0;
                    incept_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uarc_bus_link.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uarc_bus_link
//  Purpose  : Self-checking bench for uarc_bus_link: directed vector table,
//             asynchronous reset sequence, and randomized traffic against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uarc_bus_link;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_enable, s_kill, s_incept, s_send, s_stream;
    logic [W-1:0] s_data, s_self_permission, s_self_address;
    logic [W-1:0] s_incept_permission, s_incept_address;
    logic         s_kill_ack, s_incept_ack, s_send_ack, s_stream_ack;
    logic         r_enable, r_kill, r_incept, r_send, r_stream;
    logic [W-1:0] r_data, r_self_permission, r_self_address;
    logic [W-1:0] r_incept_permission, r_incept_address;
    logic         r_kill_ack, r_incept_ack, r_send_ack, r_stream_ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uarc_bus_link #(.WORD_MAG(5), .FIFO_MAG(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .s_enable            (s_enable),
        .s_kill              (s_kill),
        .s_incept            (s_incept),
        .s_send              (s_send),
        .s_stream            (s_stream),
        .s_data              (s_data),
        .s_self_permission   (s_self_permission),
        .s_self_address      (s_self_address),
        .s_incept_permission (s_incept_permission),
        .s_incept_address    (s_incept_address),
        .s_kill_ack          (s_kill_ack),
        .s_incept_ack        (s_incept_ack),
        .s_send_ack          (s_send_ack),
        .s_stream_ack        (s_stream_ack),
        .r_enable            (r_enable),
        .r_kill              (r_kill),
        .r_incept            (r_incept),
        .r_send              (r_send),
        .r_stream            (r_stream),
        .r_data              (r_data),
        .r_self_permission   (r_self_permission),
        .r_self_address      (r_self_address),
        .r_incept_permission (r_incept_permission),
        .r_incept_address    (r_incept_address),
        .r_kill_ack          (r_kill_ack),
        .r_incept_ack        (r_incept_ack),
        .r_send_ack          (r_send_ack),
        .r_stream_ack        (r_stream_ack)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // in5 = {en, send, stream, kill, incept}; acks = {recv data ack, kill ack, incept ack}
    task automatic drive(input logic [4:0] in5, input logic [W-1:0] dat,
                         input logic [W-1:0] iaddr, input logic [2:0] acks);
        s_enable            = in5[4];
        s_send              = in5[3];
        s_stream            = in5[2];
        s_kill              = in5[1];
        s_incept            = in5[0];
        s_data              = dat;
        s_incept_address    = iaddr;
        s_self_permission   = iaddr ^ 32'h1;
        s_self_address      = iaddr + 32'd1;
        s_incept_permission = iaddr + 32'd2;
        r_send_ack          = acks[2];
        r_stream_ack        = acks[2];
        r_kill_ack          = acks[1];
        r_incept_ack        = acks[0];
    endtask

    function automatic logic [8:0] flags();
        return {s_send_ack, s_stream_ack, r_send, r_stream, r_enable,
                r_kill, r_incept, s_kill_ack, s_incept_ack};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [4:0]   in5;
        logic [W-1:0] dat;
        logic [W-1:0] iaddr;
        logic [2:0]   acks;
        logic [8:0]   exp9;   // sack,stack,rsend,rstream,renable,rkill,rinc,skack,siack
        logic [W-1:0] e_rdata;
        logic [W-1:0] e_riaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] in5, input logic [W-1:0] dat,
                                input logic [W-1:0] iaddr, input logic [2:0] acks,
                                input logic [8:0] exp9, input logic [W-1:0] e_rdata,
                                input logic [W-1:0] e_riaddr);
        vec_t v;
        v.in5 = in5; v.dat = dat; v.iaddr = iaddr; v.acks = acks;
        v.exp9 = exp9; v.e_rdata = e_rdata; v.e_riaddr = e_riaddr;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic         st;
        logic [W-1:0] d;
    } mword_t;

    mword_t       mq[$];
    bit           m_iw, m_id, m_kw, m_kd;
    logic [W-1:0] m_sp, m_sa, m_ip, m_ia;

    task automatic model_reset();
        mq.delete();
        m_iw = 0; m_id = 0; m_kw = 0; m_kd = 0;
        m_sp = '0; m_sa = '0; m_ip = '0; m_ia = '0;
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic model_step();
        bit idle, emp, full, kreq, okp, e_sack, e_stack, e_rs, e_rt, pushed, popped;
        idle    = !(m_iw || m_id || m_kw || m_kd);
        emp     = (mq.size() == 0);
        full    = (mq.size() == DEPTH);
        kreq    = s_enable && s_kill;
        okp     = idle && s_enable && !s_kill && !full;
        e_sack  = okp && s_send && !s_stream;
        e_stack = okp && s_stream && !s_send;
        e_rs    = !emp && !mq[0].st;
        e_rt    = !emp && mq[0].st;

        chk("rnd s_send_ack",   s_send_ack,   e_sack);
        chk("rnd s_stream_ack", s_stream_ack, e_stack);
        chk("rnd r_send",       r_send,       e_rs);
        chk("rnd r_stream",     r_stream,     e_rt);
        chk("rnd r_enable",     r_enable,     !emp || !idle);
        chk("rnd r_kill",       r_kill,       m_kw);
        chk("rnd r_incept",     r_incept,     m_iw);
        chk("rnd s_kill_ack",   s_kill_ack,   m_kd);
        chk("rnd s_incept_ack", s_incept_ack, m_id && !kreq);
        chk("rnd r_self_perm",  r_self_permission,   m_sp);
        chk("rnd r_self_addr",  r_self_address,      m_sa);
        chk("rnd r_inc_perm",   r_incept_permission, m_ip);
        chk("rnd r_inc_addr",   r_incept_address,    m_ia);
        if (!emp) chk("rnd r_data", r_data, mq[0].d);

        if (kreq && !(m_kw || m_kd)) begin
            mq.delete();
            m_iw = 0; m_id = 0; m_kw = 1; m_kd = 0;
            m_sp = '0; m_sa = '0; m_ip = '0; m_ia = '0;
        end else begin
            popped = (e_rs && r_send_ack) || (e_rt && r_stream_ack);
            pushed = e_sack || e_stack;
            if (popped) void'(mq.pop_front());
            if (pushed) mq.push_back('{st: e_stack, d: s_data});
            if (m_kd) m_kd = 0;
            else if (m_kw) begin
                if (r_kill_ack) begin m_kw = 0; m_kd = 1; end
            end else if (m_id) m_id = 0;
            else if (m_iw) begin
                if (r_incept_ack) begin m_iw = 0; m_id = 1; end
            end else if (s_enable && s_incept && !s_kill && emp && !pushed) begin
                m_iw = 1;
                m_sp = s_self_permission; m_sa = s_self_address;
                m_ip = s_incept_permission; m_ia = s_incept_address;
            end
        end
    endtask

    initial begin
        // Single send
        vecs.push_back(mk(5'b11000, 32'hDEADBEEF, 0, 3'b000, 9'b100000000, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b100, 9'b001010000, 32'hDEADBEEF, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000000000, 0, 0));
        // Stream fill to depth, fifth word refused until a slot frees
        vecs.push_back(mk(5'b10100, 1, 0, 3'b000, 9'b010000000, 0, 0));
        vecs.push_back(mk(5'b10100, 2, 0, 3'b000, 9'b010110000, 1, 0));
        vecs.push_back(mk(5'b10100, 3, 0, 3'b000, 9'b010110000, 1, 0));
        vecs.push_back(mk(5'b10100, 4, 0, 3'b000, 9'b010110000, 1, 0));
        vecs.push_back(mk(5'b10100, 5, 0, 3'b000, 9'b000110000, 1, 0));
        vecs.push_back(mk(5'b10100, 5, 0, 3'b100, 9'b000110000, 1, 0));
        vecs.push_back(mk(5'b10100, 5, 0, 3'b100, 9'b010110000, 2, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b100, 9'b000110000, 3, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b100, 9'b000110000, 4, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b100, 9'b000110000, 5, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000000000, 0, 0));
        // Incept held behind earlier data
        vecs.push_back(mk(5'b11000, 32'h11, 0, 3'b000, 9'b100000000, 0, 0));
        vecs.push_back(mk(5'b10001, 0, 32'h40, 3'b000, 9'b001010000, 32'h11, 0));
        vecs.push_back(mk(5'b10001, 0, 32'h40, 3'b100, 9'b001010000, 32'h11, 0));
        vecs.push_back(mk(5'b10001, 0, 32'h40, 3'b000, 9'b000000000, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000010100, 0, 32'h40));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b001, 9'b000010100, 0, 32'h40));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000010001, 0, 32'h40));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000000000, 0, 32'h40));
        // Kill flushes queued words
        vecs.push_back(mk(5'b11000, 32'hA1, 0, 3'b000, 9'b100000000, 0, 32'h40));
        vecs.push_back(mk(5'b11000, 32'hA2, 0, 3'b000, 9'b101010000, 32'hA1, 32'h40));
        vecs.push_back(mk(5'b11000, 32'hA3, 0, 3'b000, 9'b101010000, 32'hA1, 32'h40));
        vecs.push_back(mk(5'b10010, 0, 0, 3'b000, 9'b001010000, 32'hA1, 32'h40));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000011000, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b010, 9'b000011000, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000010010, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000000000, 0, 0));
        // Kill pre-empts a pending incept; repeated kill ignored
        vecs.push_back(mk(5'b10001, 0, 32'h80, 3'b000, 9'b000000000, 0, 0));
        vecs.push_back(mk(5'b10010, 0, 0, 3'b001, 9'b000010100, 0, 32'h80));
        vecs.push_back(mk(5'b10010, 0, 0, 3'b000, 9'b000011000, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b010, 9'b000011000, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000010010, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000000000, 0, 0));
        // Send and stream together is refused
        vecs.push_back(mk(5'b11100, 32'h99, 0, 3'b000, 9'b000000000, 0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'b000, 9'b000000000, 0, 0));

        // Reset state
        reset = 1'b0;
        drive(5'b00000, 0, 0, 3'b000);
        #2;
        chk("reset flags", flags(), 9'b0);
        chk("reset r_data", r_data, 0);
        chk("reset r_incept_address", r_incept_address, 0);
        chk("reset r_self_permission", r_self_permission, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].in5, vecs[i].dat, vecs[i].iaddr, vecs[i].acks);
            #1;
            chk($sformatf("vec%0d flags", i), flags(), vecs[i].exp9);
            chk($sformatf("vec%0d r_incept_address", i), r_incept_address, vecs[i].e_riaddr);
            if (vecs[i].exp9[6] || vecs[i].exp9[5])
                chk($sformatf("vec%0d r_data", i), r_data, vecs[i].e_rdata);
        end

        // Asynchronous reset in the middle of a stream
        @(negedge clk);
        drive(5'b10100, 32'h55, 0, 3'b000);
        #1 chk("ar first ack", s_stream_ack, 1'b1);
        @(negedge clk);
        drive(5'b10100, 32'h66, 0, 3'b000);
        #1;
        chk("ar head stream", {r_stream, r_enable}, 2'b11);
        chk("ar head data", r_data, 32'h55);
        #2 reset = 1'b0;
        #1;
        chk("ar flags in reset", flags(), 9'b0);
        chk("ar r_data in reset", r_data, 0);
        @(negedge clk);
        drive(5'b00000, 0, 0, 3'b000);
        #2 reset = 1'b1;
        #1 chk("ar after release", flags(), 9'b0);
        @(negedge clk);
        drive(5'b11000, 32'h77, 0, 3'b000);
        #1 chk("ar new send ack", flags(), 9'b100000000);
        @(negedge clk);
        drive(5'b00000, 0, 0, 3'b100);
        #1;
        chk("ar new send visible", flags(), 9'b001010000);
        chk("ar new send data", r_data, 32'h77);

        // Randomized traffic against the reference model
        @(negedge clk);
        reset = 1'b0;
        drive(5'b00000, 0, 0, 3'b000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s_enable            = ($urandom_range(0, 99) < 85);
            s_send              = ($urandom_range(0, 99) < 40);
            s_stream            = ($urandom_range(0, 99) < 35);
            s_kill              = ($urandom_range(0, 99) < 3);
            s_incept            = ($urandom_range(0, 99) < 15);
            s_data              = $urandom();
            s_self_permission   = $urandom();
            s_self_address      = $urandom();
            s_incept_permission = $urandom();
            s_incept_address    = $urandom();
            r_send_ack          = ($urandom_range(0, 99) < 40);
            r_stream_ack        = ($urandom_range(0, 99) < 40);
            r_kill_ack          = ($urandom_range(0, 99) < 50);
            r_incept_ack        = ($urandom_range(0, 99) < 50);
            #1;
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
